// File: rtl/srlvec_fifo_ctrl_if.sv
// Valid/ready stream bundle around the SRL-backed FIFO: write side (s_*) and read side (m_*).
// The FIFO uses the slave modport; the producer/consumer environment uses master.
interface srlvec_fifo_ctrl_if #(
    parameter int NBITS = 8
);
    logic [NBITS-1:0] s_tdata;
    logic             s_tvalid;
    logic             s_tready;
    logic [NBITS-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready;

    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid
    );

    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid
    );
endinterface

// File: rtl/srlvec_fifo_ctrl.sv
// First-word-fall-through FIFO control around an external srlvec shift register.
// The SRL holds only data; pointer, occupancy and the registered output stage live here.
module srlvec_fifo_ctrl #(
    parameter int    NBITS     = 8,
    parameter string USE_SRL16 = "TRUE",
    localparam int   ADDR_BITS = (USE_SRL16 == "TRUE") ? 4 : 5
) (
    input  logic                 clk,
    input  logic                 rst,
    srlvec_fifo_ctrl_if.slave    bus,
    output logic [ADDR_BITS:0]   count,
    output logic                 srl_ce,
    output logic [NBITS-1:0]     srl_din,
    output logic [ADDR_BITS-1:0] srl_a,
    input  logic [NBITS-1:0]     srl_dout
);
    localparam int                   DEPTH    = 1 << ADDR_BITS;
    localparam int                   CW       = ADDR_BITS + 1;
    localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(DEPTH - 1);

    logic [ADDR_BITS-1:0] ptr_reg, ptr_next;
    logic                 srl_empty_reg, srl_empty_next;
    logic                 m_tvalid_reg, m_tvalid_next;
    logic [NBITS-1:0]     m_tdata_reg, m_tdata_next;
    logic [CW-1:0]        count_reg, count_next;

    logic srl_full;
    logic wr;
    logic ld;
    logic rd;

    // s_tready depends only on registered state, so a same-cycle read at full cannot open it.
    assign srl_full     = !srl_empty_reg && (ptr_reg == PTR_LAST);
    assign bus.s_tready = !srl_full;
    assign wr           = bus.s_tvalid && !srl_full;
    assign ld           = !srl_empty_reg && (!m_tvalid_reg || bus.m_tready);
    assign rd           = m_tvalid_reg && bus.m_tready;

    assign srl_ce       = wr;
    assign srl_din      = bus.s_tdata;
    assign srl_a        = ptr_reg;
    assign bus.m_tvalid = m_tvalid_reg;
    assign bus.m_tdata  = m_tdata_reg;
    assign count        = count_reg;

    always_comb begin
        ptr_next       = ptr_reg;
        srl_empty_next = srl_empty_reg;
        // On simultaneous write and load the shift moves the next-oldest entry onto ptr.
        if (wr && !ld) begin
            if (srl_empty_reg) begin
                srl_empty_next = 1'b0;
            end else begin
                ptr_next = ptr_reg + ADDR_BITS'(1);
            end
        end else if (ld && !wr) begin
            if (ptr_reg == '0) begin
                srl_empty_next = 1'b1;
            end else begin
                ptr_next = ptr_reg - ADDR_BITS'(1);
            end
        end
    end

    always_comb begin
        m_tvalid_next = m_tvalid_reg;
        m_tdata_next  = m_tdata_reg;
        if (ld) begin
            m_tvalid_next = 1'b1;
            m_tdata_next  = srl_dout;
        end else if (bus.m_tready) begin
            m_tvalid_next = 1'b0;
        end
        count_next = count_reg + CW'(wr) - CW'(rd);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            srl_empty_reg <= 1'b1;
            m_tvalid_reg  <= 1'b0;
            m_tdata_reg   <= '0;
            count_reg     <= '0;
        end else begin
            ptr_reg       <= ptr_next;
            srl_empty_reg <= srl_empty_next;
            m_tvalid_reg  <= m_tvalid_next;
            m_tdata_reg   <= m_tdata_next;
            count_reg     <= count_next;
        end
    end
endmodule

// File: tb/tb_srlvec_fifo_ctrl.sv
// Bench for srlvec_fifo_ctrl: SRL16 and SRL32 configurations driven with the same stimulus,
// each with its own srlvec model, occupancy reference model and output scoreboard.
module tb_srlvec_fifo_ctrl;
    localparam int NBITS = 8;
    localparam int NCFG  = 2;

    logic clk = 1'b0;
    logic rst;
    logic s_tvalid;
    logic m_tready;
    logic [NBITS-1:0] s_tdata;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [NCFG-1:0]  tv;
    logic [NCFG-1:0]  tr;
    logic [NBITS-1:0] td    [NCFG];
    int               cnt_o [NCFG];
    int               a_o   [NCFG];
    int               n_out [NCFG];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam string CFG = (gi == 0) ? "TRUE" : "FALSE";
        localparam int    AB  = (gi == 0) ? 4 : 5;
        localparam int    D   = 1 << AB;

        srlvec_fifo_ctrl_if #(.NBITS(NBITS)) bus ();

        logic [AB:0]      count;
        logic             srl_ce;
        logic [NBITS-1:0] srl_din;
        logic [NBITS-1:0] srl_dout;
        logic [AB-1:0]    srl_a;
        logic [NBITS-1:0] srl_mem [D];

        assign bus.s_tdata  = s_tdata;
        assign bus.s_tvalid = s_tvalid;
        assign bus.m_tready = m_tready;

        srlvec_fifo_ctrl #(.NBITS(NBITS), .USE_SRL16(CFG)) dut (
            .clk      (clk),
            .rst      (rst),
            .bus      (bus),
            .count    (count),
            .srl_ce   (srl_ce),
            .srl_din  (srl_din),
            .srl_a    (srl_a),
            .srl_dout (srl_dout)
        );

        // srlvec model: shift in at position 0, asynchronous addressed read
        always @(posedge clk) begin
            if (srl_ce) begin
                for (int i = D - 1; i > 0; i--) srl_mem[i] <= srl_mem[i-1];
                srl_mem[0] <= srl_din;
            end
        end
        assign srl_dout = srl_mem[srl_a];

        // Reference: words waiting in the SRL, output-register flag, queue of undelivered words
        int               mdl_srl_n;
        logic             mdl_ov;
        logic             mdl_wr;
        logic             mdl_ld;
        logic [NBITS-1:0] exp_q [$];

        assign mdl_wr = s_tvalid && (mdl_srl_n < D);
        assign mdl_ld = (mdl_srl_n > 0) && (!mdl_ov || m_tready);

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mdl_srl_n <= 0;
                mdl_ov    <= 1'b0;
                exp_q.delete();
            end else begin
                if (mdl_wr) exp_q.push_back(s_tdata);
                mdl_srl_n <= mdl_srl_n + int'(mdl_wr) - int'(mdl_ld);
                mdl_ov    <= mdl_ld ? 1'b1 : (m_tready ? 1'b0 : mdl_ov);
            end
        end

        logic             stalled;
        logic [NBITS-1:0] stall_data;
        int               prev_a;
        int               a_diff;
        int               n_out_r;

        assign a_diff = int'(srl_a) - prev_a;

        always @(negedge clk or posedge rst) begin
            if (rst) begin
                stalled    <= 1'b0;
                stall_data <= '0;
                prev_a     <= 0;
            end else begin
                check($sformatf("cfg%0d_m_tvalid", gi), bus.m_tvalid, mdl_ov);
                check($sformatf("cfg%0d_s_tready", gi), bus.s_tready, mdl_srl_n < D);
                check($sformatf("cfg%0d_count", gi), count, mdl_srl_n + int'(mdl_ov));
                check($sformatf("cfg%0d_srl_a", gi), srl_a, (mdl_srl_n == 0) ? 0 : mdl_srl_n - 1);
                checks++;
                assert (a_diff >= -1 && a_diff <= 1)
                else begin
                    failures++;
                    $display("FAIL cfg%0d_ptr_no_wrap actual=%0d->%0d required=step of at most 1",
                             gi, prev_a, srl_a);
                end
                if (stalled) begin
                    check($sformatf("cfg%0d_stall_valid", gi), bus.m_tvalid, 1);
                    check($sformatf("cfg%0d_stall_data", gi), bus.m_tdata, stall_data);
                end
                if (bus.m_tvalid) begin
                    check($sformatf("cfg%0d_sb_nonempty", gi), exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check($sformatf("cfg%0d_m_tdata", gi), bus.m_tdata, exp_q[0]);
                        if (m_tready) begin
                            $display("cfg%0d out 0x%02h count=%0d", gi, bus.m_tdata, count);
                            void'(exp_q.pop_front());
                        end
                    end
                end
                if (bus.m_tvalid && m_tready) n_out_r <= n_out_r + 1;
                stalled    <= bus.m_tvalid && !m_tready;
                stall_data <= bus.m_tdata;
                prev_a     <= int'(srl_a);
            end
        end

        initial n_out_r = 0;

        assign tv[gi]    = bus.m_tvalid;
        assign tr[gi]    = bus.s_tready;
        assign td[gi]    = bus.m_tdata;
        assign cnt_o[gi] = int'(count);
        assign a_o[gi]   = int'(srl_a);
        assign n_out[gi] = n_out_r;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int c = 0; c < budget && (cnt_o[0] != 0 || cnt_o[1] != 0); c++) step();
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) check($sformatf("drain_count_cfg%0d", i), cnt_o[i], 0);
        step();
    endtask

    int snap [NCFG];

    initial begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        rst      = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("reset_m_tvalid_cfg%0d", i), tv[i], 0);
            check($sformatf("reset_m_tdata_cfg%0d", i), td[i], 0);
            check($sformatf("reset_count_cfg%0d", i), cnt_o[i], 0);
            check($sformatf("reset_s_tready_cfg%0d", i), tr[i], 1);
        end

        // single word: 2-cycle write-to-valid, count 0->1->1->0
        step();
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 8'hA5;
        step();
        s_tvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("lat1_m_tvalid_cfg%0d", i), tv[i], 0);
            check($sformatf("lat1_count_cfg%0d", i), cnt_o[i], 1);
        end
        step();
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("lat2_m_tvalid_cfg%0d", i), tv[i], 1);
            check($sformatf("lat2_m_tdata_cfg%0d", i), td[i], 8'hA5);
            check($sformatf("lat2_count_cfg%0d", i), cnt_o[i], 1);
        end
        step();
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("lat3_m_tvalid_cfg%0d", i), tv[i], 0);
            check($sformatf("lat3_count_cfg%0d", i), cnt_o[i], 0);
            check($sformatf("lat3_srl_a_cfg%0d", i), a_o[i], 0);
            check($sformatf("lat3_s_tready_cfg%0d", i), tr[i], 1);
        end
        step();

        // fill with m_tready low: SRL16 takes 17 words, SRL32 takes 33
        m_tready = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(k);
            step();
        end
        s_tvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("full_count_cfg%0d", i), cnt_o[i], (16 << i) + 1);
            check($sformatf("full_srl_a_cfg%0d", i), a_o[i], (16 << i) - 1);
            check($sformatf("full_s_tready_cfg%0d", i), tr[i], 0);
            snap[i] = n_out[i];
        end
        step();
        drain(80);
        for (int i = 0; i < NCFG; i++)
            check($sformatf("full_drained_words_cfg%0d", i), n_out[i] - snap[i], (16 << i) + 1);

        // steady state with 4 words queued: one in, one out per cycle
        m_tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(8'h40 + k);
            step();
        end
        m_tready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(8'h44 + c);
            @(negedge clk);
            for (int i = 0; i < NCFG; i++) begin
                check($sformatf("steady_count_cfg%0d", i), cnt_o[i], 4);
                check($sformatf("steady_srl_a_cfg%0d", i), a_o[i], 2);
                check($sformatf("steady_m_tvalid_cfg%0d", i), tv[i], 1);
            end
            step();
        end
        drain(80);

        // random handshakes, checked every cycle by the monitors
        for (int c = 0; c < 10000; c++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = 8'($urandom);
            step();
        end
        drain(80);

        // asynchronous reset with 10 words queued
        m_tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(8'hC0 + k);
            step();
        end
        s_tvalid = 1'b0;
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("prerst_count_cfg%0d", i), cnt_o[i], 10);
            check($sformatf("prerst_m_tvalid_cfg%0d", i), tv[i], 1);
        end
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("rst_m_tvalid_cfg%0d", i), tv[i], 0);
            check($sformatf("rst_count_cfg%0d", i), cnt_o[i], 0);
            check($sformatf("rst_s_tready_cfg%0d", i), tr[i], 1);
            snap[i] = n_out[i];
        end
        #1 rst = 1'b0;
        step();
        m_tready = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = 8'h5A;
        step();
        s_tvalid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) check($sformatf("post_rst_lat1_cfg%0d", i), tv[i], 0);
        step();
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("post_rst_valid_cfg%0d", i), tv[i], 1);
            check($sformatf("post_rst_data_cfg%0d", i), td[i], 8'h5A);
        end
        step();
        step();
        @(negedge clk);
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("post_rst_words_cfg%0d", i), n_out[i] - snap[i], 1);
            check($sformatf("post_rst_count_cfg%0d", i), cnt_o[i], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/srlvec_fifo_ctrl.md
Name: srlvec_fifo_ctrl

Overview:
- Control and output stage that wraps a vectorized SRL shift register (srlvec) into a first-word-fall-through FIFO with a valid/ready interface on both sides.
- Drives the SRL's shift enable, data-in and read address.
- Consumes the SRL's addressed output into a registered output stage.
- Sits directly around an srlvec instance: owns all pointer/occupancy state; the SRL holds only data.

Parameters:
- NBITS, 8, data width; must match the attached srlvec.
- USE_SRL16, "TRUE", "TRUE" gives SRL depth D=16 with ADDR_BITS=4; otherwise D=32 with ADDR_BITS=5. Must match the attached srlvec.
- ADDR_BITS (localparam), 4 or 5 as above.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_tdata  in  NBITS  write data.
- s_tvalid  in  1  write request.
- s_tready  out  1  FIFO can accept; s_tready = !srl_full, from registered state only.
- m_tdata  out  NBITS  registered output data.
- m_tvalid  out  1  output register holds valid data.
- m_tready  in  1  downstream accepts.
- count  out  ADDR_BITS+1  total occupancy, range 0..D+1 (SRL entries plus output register).
- srl_ce  out  1  to srlvec ce.
- srl_din  out  NBITS  to srlvec din; equals s_tdata, combinational.
- srl_a  out  ADDR_BITS  to srlvec a; equals ptr, registered.
- srl_dout  in  NBITS  from srlvec dout; combinational read of SRL[srl_a].

Behaviour:
- State: ptr (ADDR_BITS), srl_empty (1), m_tvalid, m_tdata, count.
- Reset values: ptr=0, srl_empty=1, m_tvalid=0, m_tdata=0, count=0. SRL contents are not reset; they are ignored while srl_empty=1. Reset asserted mid-operation discards all entries immediately, with no output pulse.
- When !srl_empty, ptr addresses the oldest SRL entry; the SRL holds ptr+1 entries.
- srl_full = !srl_empty && ptr==D-1.
- wr = s_tvalid && s_tready; srl_ce = wr. A write shifts s_tdata into SRL position 0; existing entries move up by one.
- ld = !srl_empty && (!m_tvalid || m_tready). On ld, m_tdata <= srl_dout, sampled before the shift at the same edge.
- Pointer update:
  - wr && !ld: if srl_empty then srl_empty<=0 and ptr stays 0; else ptr<=ptr+1.
  - ld && !wr: if ptr==0 then srl_empty<=1; else ptr<=ptr-1.
  - wr && ld: ptr and srl_empty unchanged. The shift moves the next-oldest entry to address ptr.
  - Neither: hold.
- m_tvalid next: 1 if ld; else 0 if m_tready; else hold. m_tdata holds while m_tvalid && !m_tready (AXI-stream stability).
- count next = count + wr - (m_tvalid && m_tready). It never exceeds D+1 and never underflows.
- Latency: a word written into an empty FIFO at edge N appears with m_tvalid=1 after edge N+1, i.e. 2 cycles write-to-valid. There is no bypass path.
- Throughput: with the SRL non-empty and m_tready=1, one word per cycle in and out sustained.
- Boundaries:
  - Full (srl_full and m_tvalid): s_tready=0; s_tvalid ignored; count=D+1.
  - Writes are accepted while count=D, filling the SRL to D entries.
  - Read and write in the same cycle at full: the write is still blocked (s_tready is registered-state only) and the read frees a slot for the next cycle.
  - Empty: srl_ce only on wr; srl_a=0.
  - ptr never wraps; the full/empty guards make the wrap unreachable, and an assertion on this belongs in the bench.
- Ordering: strict FIFO; no data loss or duplication under any valid/ready pattern.

Test Plan:
1. Reset, then a single write of 0xA5 with m_tready=1 -> m_tvalid=1 with m_tdata=0xA5 exactly 2 cycles after the write edge; count goes 0->1->1->0 after the read; srl_empty back to 1.
2. USE_SRL16="TRUE", m_tready=0, write 0x00..0x20 continuously -> s_tready drops after 17 accepted words; count=17, ptr=15; then drain with m_tready=1 -> output 0x00..0x10 in order, count reaches 0.
3. Same as scenario 2 with USE_SRL16="FALSE" -> 33 words accepted, count=33, ptr=31, in-order drain.
4. Steady state with 4 words queued, s_tvalid=m_tready=1 for 100 cycles, incrementing data -> ptr stays 2, count stays 4, output is strictly incrementing with no gaps.
5. Random s_tvalid/m_tready (50%) for 10k cycles with a scoreboard -> in-order, lossless output; m_tdata stable while stalled; count matches the scoreboard every cycle.
6. Assert rst mid-burst with 10 words queued and m_tvalid=1 -> m_tvalid=0, count=0, s_tready=1 immediately (asynchronous); the next write 0x5A is output alone after 2 cycles.
